// File: rtl/button_debounce_reader.sv
// Pushbutton reader: 2-flop sync, counter-qualified debounce, level and event pulses.
// Optional AUTO_REPEAT_EN adds periodic repeats on long_press_pulse while held.
module button_debounce_reader #(
  parameter int DEBOUNCE_CYCLES   = 41_600,
  parameter int LONG_PRESS_CYCLES = 2_080_000,
  parameter int REPEAT_CYCLES     = 520_000,
  parameter int ACTIVE_LOW_IN     = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_rep
    $error("REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t state, state_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [HW-1:0] hold_cnt;
  logic pin_p, sync_m, sync_p;
  logic holding, holding_n;
  logic level_n, press_n, release_n, long_n;
  logic long_hit, fired, long_first, rep_fire;

  assign pin_p = (ACTIVE_LOW_IN != 0) ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_m <= 1'b0;
      sync_p <= 1'b0;
    end else begin
      sync_m <= pin_p;
      sync_p <= sync_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      state   <= state_n;
      deb_cnt <= deb_n;
    end
  end

  always_comb begin
    state_n = state;
    deb_n   = deb_cnt;
    unique case (state)
      IDLE: begin
        if (sync_p) begin
          state_n = PRESS_WAIT;
          deb_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_p)
          state_n = IDLE;
        else if (deb_cnt == DEB_LAST)
          state_n = PRESSED;
        else
          deb_n = deb_cnt + 1'b1;
      end
      PRESSED: begin
        if (!sync_p) begin
          state_n = RELEASE_WAIT;
          deb_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_p)
          state_n = PRESSED;
        else if (deb_cnt == DEB_LAST)
          state_n = IDLE;
        else
          deb_n = deb_cnt + 1'b1;
      end
    endcase
  end

  always_comb begin
    holding    = (state == PRESSED) || (state == RELEASE_WAIT);
    holding_n  = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    level_n    = holding_n;
    press_n    = (state == PRESS_WAIT) && (state_n == PRESSED);
    release_n  = (state == RELEASE_WAIT) && (state_n == IDLE);
    long_first = holding && holding_n && long_hit && !fired;
    long_n     = long_first || (holding && holding_n && rep_fire);
  end

  // hold_cnt survives release bounces; only a fresh press restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      long_hit <= 1'b0;
      fired    <= 1'b0;
    end else begin
      if (press_n)
        hold_cnt <= '0;
      else if (holding && hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + 1'b1;
      long_hit <= holding && (hold_cnt == HOLD_LAST);
      if (state_n == IDLE)
        fired <= 1'b0;
      else if (long_first)
        fired <= 1'b1;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rep_cnt <= '0;
    else if (long_first || !fired)
      rep_cnt <= '0;
    else if (holding)
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
  end

  assign rep_fire = fired && (rep_cnt == REP_LAST);
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      btn_level        <= level_n;
      press_pulse      <= press_n;
      release_pulse    <= release_n;
      long_press_pulse <= long_n;
    end
  end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Randomized scoreboard bench for button_debounce_reader against a run-length model.
module tb_button_debounce_reader;

  localparam int DEB = 8;
  localparam int LP  = 40;
  localparam int REP = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_press_pulse;

  always #5 clk = ~clk;

  button_debounce_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LP),
    .REPEAT_CYCLES(REP),
    .ACTIVE_LOW_IN(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic lng;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: run length of samples disagreeing with the accepted level
  bit   m_lvl = 1'b0;
  int   m_run = 0;
  int   m_e = 0;
  int   m_pt = -100000;
  bit   dl[$];
  exp_t m_out = '0;

  function automatic void model_reset();
    m_lvl = 1'b0;
    m_run = 0;
    m_out = '0;
    dl.delete();
    dl.push_back(1'b0);
    dl.push_back(1'b0);
  endfunction

  function automatic void model_edge(input bit pin);
    bit x;
    int since;
    m_e++;
    dl.push_back(pin);
    x = dl.pop_front();
    m_out = '0;
    if (x != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == DEB + 1) begin
      m_lvl = !m_lvl;
      m_run = 0;
      if (m_lvl) begin
        m_out.press = 1'b1;
        m_pt = m_e;
      end else begin
        m_out.rel = 1'b1;
      end
    end
    m_out.lvl = m_lvl;
    since = m_e - m_pt;
    if (m_lvl && !m_out.press) begin
`ifdef AUTO_REPEAT_EN
      if (since >= LP + 1 && ((since - LP - 1) % REP) == 0)
        m_out.lng = 1'b1;
`else
      if (since == LP + 1)
        m_out.lng = 1'b1;
`endif
    end
  endfunction

  task automatic step(input bit pressed, input bit rst);
    btn_raw = ~pressed;
    reset_n = ~rst;
    if (rst) begin
      model_reset();
      q.push_back('0);
    end else begin
      q.push_back(m_out);
    end
    @(posedge clk);
    if (!rst) model_edge(pressed);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      got.lvl   = btn_level;
      got.press = press_pulse;
      got.rel   = release_pulse;
      got.lng   = long_press_pulse;
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: lvl/press/rel/long got %b required %b",
                 cyc, got, e);
      end
    end
  end

  int lows[3] = '{3, 5, 7};

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b1);
    repeat (50) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    foreach (lows[i]) begin
      repeat (lows[i]) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
    end
    repeat (12) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (100) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    repeat (60) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    repeat (60) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    repeat (150) begin
      int len;
      bit p;
      p = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 90)
                                        : $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0)
        repeat ($urandom_range(1, 3)) step(p, 1'b1);
      repeat (len) step(p, 1'b0);
    end
    repeat (40) step(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
